// File: rtl/input_cond_pkg.sv
// Shared types and defaults for the input conditioner and its per-channel debouncers.
package input_cond_pkg;

  typedef enum logic {
    StStable,
    StPending
  } ch_state_e;

  // 5 ms at 100 MHz
  localparam int unsigned DefaultDebounceDelay = 500000;
  localparam int unsigned DefaultCntW          = 20;

endpackage

// File: rtl/debounce_channel.sv
// One input bit: two-flop synchroniser, optional inversion, and a counting debounce FSM
// that emits a registered press/release strobe in the cycle the new level is accepted.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_DELAY = DefaultDebounceDelay,
  parameter int unsigned CNT_W          = DefaultCntW,
  parameter logic        INV            = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic press,
  output logic rel,
  output logic accept
);

  localparam logic [CNT_W-1:0] DelayCnt = CNT_W'(DEBOUNCE_DELAY);

  logic             sync1_q;
  logic             sync2_q;
  logic             sample;
  logic             mismatch;
  ch_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clean_q;
  logic             press_q;
  logic             rel_q;

  // Synchroniser resets to INV so the conditioned sample starts inactive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= INV;
      sync2_q <= INV;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign sample   = sync2_q ^ INV;
  assign mismatch = sample != clean_q;
  assign accept   = (state_q == StPending) && mismatch && (cnt_q == DelayCnt);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StStable;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      unique case (state_q)
        StStable: begin
          if (mismatch) begin
            state_q <= StPending;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        StPending: begin
          if (!mismatch) begin
            state_q <= StStable;
            cnt_q   <= '0;
          end else if (cnt_q == DelayCnt) begin
            state_q <= StStable;
            cnt_q   <= '0;
            clean_q <= sample;
            press_q <= sample;
            rel_q   <= ~sample;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign clean = clean_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises, polarity-corrects and debounces NUM_CH board inputs, producing clean
// levels, per-channel press/release strobes and a combined change strobe.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned        NUM_CH         = 3,
  parameter int unsigned        DEBOUNCE_DELAY = DefaultDebounceDelay,
  parameter int unsigned        CNT_W          = DefaultCntW,
  parameter logic [NUM_CH-1:0]  INV_MASK       = NUM_CH'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] clean_lvl,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic              any_change
);

  logic [NUM_CH-1:0] accept;
  logic              any_change_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_DELAY (DEBOUNCE_DELAY),
      .CNT_W          (CNT_W),
      .INV            (INV_MASK[i])
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_in[i]),
      .clean  (clean_lvl[i]),
      .press  (press_pulse[i]),
      .rel    (release_pulse[i]),
      .accept (accept[i])
    );
  end

  // Registered from the channels' accept terms so it lines up with their pulse flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |accept;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Upstream front end for the switch/button inputs feeding the sequence-detector/display counter stage. Synchronises NUM_CH raw board inputs to clk and applies per-channel polarity correction and per-channel debounce. Produces clean levels plus single-cycle press/release strobes. The downstream stage consumes clean_lvl for its sw1/sw2 decode and press_pulse for its click counting, and needs no synchroniser or debounce logic of its own.

Parameters:
NUM_CH, 3, number of independent input channels
DEBOUNCE_DELAY, 500000, consecutive mismatch cycles required to accept a new level (5 ms at 100 MHz); legal range 2..2^CNT_W-1
CNT_W, 20, debounce counter width; must hold DEBOUNCE_DELAY
INV_MASK, 3'b001, per-channel bit; 1 = raw input is active-low and is inverted after synchronisation

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
raw_in  input  NUM_CH  unsynchronised board switches/buttons
clean_lvl  output  NUM_CH  debounced, polarity-corrected level (1 = active)
press_pulse  output  NUM_CH  one-cycle strobe on accepted 0->1 of clean_lvl
release_pulse  output  NUM_CH  one-cycle strobe on accepted 1->0 of clean_lvl
any_change  output  1  one-cycle OR of all press_pulse/release_pulse bits

Behaviour:
- Reset: asynchronous, active-low; flops clear on reset low regardless of clk, release synchronous to next clk edge.
- Reset values: clean_lvl=0, press_pulse=0, release_pulse=0, any_change=0, all counters 0, all channel FSMs in STABLE. Synchroniser flops reset to INV_MASK[i], so the conditioned sample reads 0 out of reset and no spurious event occurs.
- Synchroniser: two flops per channel (q1, q2). Conditioned sample s[i] = q2[i] XOR INV_MASK[i].
- Per-channel FSM, STABLE and PENDING:
  - STABLE: counter holds 0. If s != clean_lvl, move to PENDING with counter <= 1.
  - PENDING, s == clean_lvl (bounce back): return to STABLE, counter <= 0, no pulse.
  - PENDING, s != clean_lvl and counter < DEBOUNCE_DELAY: counter <= counter+1.
  - PENDING, s != clean_lvl and counter == DEBOUNCE_DELAY: clean_lvl <= s, matching pulse <= 1 for exactly one cycle, counter <= 0, go to STABLE.
- Net effect: the new level is accepted after DEBOUNCE_DELAY+1 consecutive mismatching samples.
- Latency: a raw change held steady appears on clean_lvl DEBOUNCE_DELAY+3 rising edges after the first edge that samples it (2 synchroniser edges + DEBOUNCE_DELAY+1).
- Pulses are registered and coincide with the clean_lvl update cycle. press_pulse and release_pulse are never both high on one channel.
- any_change is registered and asserts in the same cycle as the pulses.
- Channels are fully independent. Simultaneous acceptance on several channels raises each channel's pulse in the same cycle; any_change is a single 1-cycle strobe.
- Counter never wraps; the compare at DEBOUNCE_DELAY always terminates PENDING.
- Reset asserted mid-PENDING aborts the pending change: no pulse, clean_lvl=0.
- After reset release with raw input already active, the channel debounces normally and produces one press_pulse.

Decomposition:
- Shared package input_cond_pkg holds: channel state enum {STABLE, PENDING}, default DEBOUNCE_DELAY, and the default CNT_W constant.
- One sub-module debounce_channel (synchroniser + FSM + counter + pulse flops for one bit), instantiated NUM_CH times by a generate loop.
- The top level holds only INV_MASK wiring and the any_change OR/register.

Test Plan:
All scenarios run with DEBOUNCE_DELAY=4, NUM_CH=3, INV_MASK=3'b001.
1. Reset with raw_in=3'b001, hold 20 cycles -> clean_lvl=000, no pulses, any_change=0 throughout.
2. raw_in[1] 0->1 held -> clean_lvl[1]=1 exactly 7 edges later; press_pulse[1] high 1 cycle; any_change high same cycle. Then 1->0 held -> release_pulse[1] 1 cycle after 7 edges.
3. Bounce raw_in[2] high for 3 cycles then low, repeated 5 times -> clean_lvl[2] stays 0, no pulses. Then hold high 10 cycles -> single press_pulse[2].
4. raw_in[0] 1->0 (active-low button press) -> clean_lvl[0]=1 and press_pulse[0] after 7 edges.
5. raw_in[1] and raw_in[2] rise on the same edge -> press_pulse=3'b110 in one cycle, any_change single 1-cycle strobe.
6. Assert reset 2 cycles into a PENDING interval on channel 1 -> all outputs 0 immediately (async). After release with raw_in[1] still 1 -> one press_pulse[1] 7 edges after release.
